full_adder_unit: RTL and testbench

Registered ripple-carry full adder: adds two WIDTH-bit operands and a carry-in. Exposes the combinational sum/carry for zero-latency use and a one-cycle registered copy qualified by a valid strobe. Used as the basic arithmetic cell in datapaths; WIDTH=1 is the classic 1-bit full adder.

---
 rtl/full_adder_unit.sv | 95 +++++++++
 tb/tb_full_adder_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_unit.sv
// full_adder_unit: ripple-carry adder of WIDTH cascaded 1-bit full-adder cells.
// The sum and carry are available combinationally, and a registered copy is
// qualified by out_valid one cycle after valid operands.
// Optional feature macro: FULL_ADDER_OVF_EN adds the registered signed-overflow
// output ovf_q.
module full_adder_unit #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic [WIDTH-1:0] sum_q,
   output logic             carry_q,
`ifdef FULL_ADDER_OVF_EN
   output logic             ovf_q,
`endif
   output logic             out_valid
);

   // c[i] is the carry into cell i; c[WIDTH] is the carry out of the MSB.
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;

   logic [WIDTH-1:0] sum_d;
   logic             carry_d;
   logic             out_valid_d;
   logic             out_valid_q;

   // Ripple chain: each cell takes its carry from the cell below it.
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign sum   = s;
   assign carry = c[WIDTH];

   // Next-state values: capture on valid input, otherwise hold the result.
   always_comb begin
      sum_d       = sum_q;
      carry_d     = carry_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         sum_d   = s;
         carry_d = c[WIDTH];
      end
   end

   // Result registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q       <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;

`ifdef FULL_ADDER_OVF_EN
   logic ovf_d;

   // Signed overflow: the carry into the MSB differs from the carry out of it.
   always_comb begin
      ovf_d = ovf_q;
      if (in_valid) begin
         ovf_d = c[WIDTH] ^ c[WIDTH-1];
      end
   end

   // Overflow register, captured alongside sum_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// Testbench for full_adder_unit: a 1-bit and an 8-bit instance share the same
// stimulus. Expected registered results go into a scoreboard queue when the
// stimulus is driven, and they are popped when out_valid is seen.
module tb_full_adder_unit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] a8, b8;
   logic       a1, b1;
   logic       cin;

   logic [7:0] sum8, sum_q8;
   logic       carry8, carry_q8, out_valid8;
   logic       sum1, sum_q1;
   logic       carry1, carry_q1, out_valid1;
`ifdef FULL_ADDER_OVF_EN
   logic       ovf_q8, ovf_q1;
`endif

   int checks;
   int failures;

   typedef struct {
      logic [7:0] s8;
      logic       c8;
      logic       o8;
      logic       s1;
      logic       c1;
      logic       o1;
   } exp_t;

   exp_t sb[$];
   exp_t held;

   full_adder_unit #(.WIDTH(8)) u_dut_w8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a8),
      .b         (b8),
      .cin       (cin),
      .sum       (sum8),
      .carry     (carry8),
      .sum_q     (sum_q8),
      .carry_q   (carry_q8),
`ifdef FULL_ADDER_OVF_EN
      .ovf_q     (ovf_q8),
`endif
      .out_valid (out_valid8)
   );

   full_adder_unit #(.WIDTH(1)) u_dut_w1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a1),
      .b         (b1),
      .cin       (cin),
      .sum       (sum1),
      .carry     (carry1),
      .sum_q     (sum_q1),
      .carry_q   (carry_q1),
`ifdef FULL_ADDER_OVF_EN
      .ovf_q     (ovf_q1),
`endif
      .out_valid (out_valid1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it when it does not match.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compare the registered outputs of both instances against an expectation.
   task automatic chk_regs(input string tag, input exp_t e);
      chk({tag, "_w8_sum_q"},   32'(sum_q8),   32'(e.s8));
      chk({tag, "_w8_carry_q"}, 32'(carry_q8), 32'(e.c8));
      chk({tag, "_w1_sum_q"},   32'(sum_q1),   32'(e.s1));
      chk({tag, "_w1_carry_q"}, 32'(carry_q1), 32'(e.c1));
`ifdef FULL_ADDER_OVF_EN
      chk({tag, "_w8_ovf_q"},   32'(ovf_q8),   32'(e.o8));
      chk({tag, "_w1_ovf_q"},   32'(ovf_q1),   32'(e.o1));
`endif
   endtask

   // Drive one cycle of stimulus, then check the combinational and registered results.
   task automatic step(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic ci);
      exp_t       e;
      exp_t       got;
      logic [8:0] r8;
      logic [1:0] r1;
      @(negedge clk);
      in_valid = v;
      a8  = av;
      b8  = bv;
      a1  = av[0];
      b1  = bv[0];
      cin = ci;
      r8 = 9'(av) + 9'(bv) + 9'(ci);
      r1 = 2'(av[0]) + 2'(bv[0]) + 2'(ci);
      e.s8 = r8[7:0];
      e.c8 = r8[8];
      e.o8 = (av[7] == bv[7]) && (r8[7] != av[7]);
      e.s1 = r1[0];
      e.c1 = r1[1];
      e.o1 = (av[0] == bv[0]) && (r1[0] != av[0]);
      #1;
      chk("w8_sum",   32'(sum8),   32'(e.s8));
      chk("w8_carry", 32'(carry8), 32'(e.c8));
      chk("w1_sum",   32'(sum1),   32'(e.s1));
      chk("w1_carry", 32'(carry1), 32'(e.c1));
      if (v) sb.push_back(e);
      @(posedge clk);
      #1;
      chk("w8_out_valid", 32'(out_valid8), 32'(v));
      chk("w1_out_valid", 32'(out_valid1), 32'(v));
      if (out_valid8) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            got  = sb.pop_front();
            held = got;
            chk_regs("cap", got);
         end
      end else begin
         chk_regs("hold", held);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      held     = '{s8: 8'h00, c8: 1'b0, o8: 1'b0, s1: 1'b0, c1: 1'b0, o1: 1'b0};
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a8 = 8'h00; b8 = 8'h00; a1 = 1'b0; b1 = 1'b0; cin = 1'b0;

      // Reset state; combinational path is live while in reset.
      #1;
      chk_regs("rst", held);
      chk("rst_w8_out_valid", 32'(out_valid8), 32'd0);
      chk("rst_w1_out_valid", 32'(out_valid1), 32'd0);
      a8 = 8'h12; b8 = 8'h34; cin = 1'b1;
      #1;
      chk("rst_w8_sum_comb", 32'(sum8), 32'h47);
      @(negedge clk);
      rst_n = 1'b1;

      // 1-bit truth table: a,b,cin from the loop index.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, {7'h00, i[2]}, {7'h00, i[1]}, i[0]);
      end

      // Capture 1+1+1 so the 1-bit registers both hold 1, then reset mid-cycle.
      step(1'b1, 8'h01, 8'h01, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      held = '{s8: 8'h00, c8: 1'b0, o8: 1'b0, s1: 1'b0, c1: 1'b0, o1: 1'b0};
      sb.delete();
      chk_regs("midrst", held);
      chk("midrst_w8_out_valid", 32'(out_valid8), 32'd0);
      chk("midrst_w1_out_valid", 32'(out_valid1), 32'd0);
      chk("midrst_w1_sum_comb",  32'(sum1), 32'd1);
      chk("midrst_w1_carry_comb", 32'(carry1), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Latency and full wrap.
      step(1'b1, 8'hFF, 8'h01, 1'b0);
      // Hold: capture 0x2A, then new operands without valid.
      step(1'b1, 8'h2A, 8'h00, 1'b0);
      step(1'b0, 8'h55, 8'h11, 1'b1);
      step(1'b0, 8'hC3, 8'h7E, 1'b0);
      // Back-to-back valid results.
      step(1'b1, 8'h10, 8'h20, 1'b1);
      step(1'b1, 8'h80, 8'h80, 1'b0);
      // Signed overflow boundaries.
      step(1'b1, 8'h7F, 8'h01, 1'b0);
      step(1'b1, 8'hFF, 8'h01, 1'b0);
      step(1'b1, 8'h80, 8'hFF, 1'b1);
      // Random traffic with random valid.
      for (int k = 0; k < 40; k++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end
      step(1'b0, 8'h00, 8'h00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
